sequential_multiplier: RTL and testbench
========================================

Name: sequential_multiplier

Overview:
- Unsigned shift-and-add multiplier; free-running, no start/done handshake.
- Continuously re-samples operands A and B, computes A*B over WIDTH iterations, and publishes the product on a registered output.
- Used as a small low-area arithmetic unit where operands are quasi-static and several cycles of latency are acceptable.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH. WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- multiply  output  2*WIDTH  registered product; holds last completed result.

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset). All state updates on rising clk edge only.
- Reset: multiply=0, state=LOAD, internal accumulator, shifted operands and iteration counter all cleared. Reset has priority over all other activity, including mid-computation; in-flight result discarded.
- FSM states: LOAD -> CALC -> DONE -> LOAD, looping forever while reset=0.
- LOAD (1 cycle): capture a_sh = zero-extended A (2*WIDTH bits), b_sh = B, acc = 0, count = 0. Next state CALC.
- CALC (exactly WIDTH cycles): if b_sh[0], acc = acc + a_sh (2*WIDTH-bit add, no overflow possible); a_sh <<= 1; b_sh >>= 1; count++. Leave to DONE after the WIDTH-th iteration. No early termination when b_sh reaches 0, so timing is data-independent.
- DONE (1 cycle): multiply <= acc. Next state LOAD.
- Period: WIDTH+2 cycles per result (6 at default). multiply changes only on the DONE edge, WIDTH+1 edges after the sampling LOAD edge.
- Operand changes between LOAD edges are ignored until the next LOAD. multiply keeps the previous product until the new one completes.
- Worst-case latency from an operand change to the correct product: 2*(WIDTH+2) cycles (12 at default).
- Stable operands: multiply is rewritten with the same value each period, so it is glitch-free and constant.
- Boundaries:
  - Either operand 0 -> product 0.
  - Max operands (15*15) -> 225 (8'hE1), full width, no truncation.
  - X/Z on A or B is not defined and not required to be handled.

Optional Feature:
- Macro SEQ_MULT_DONE_EN.
- Defined: adds output port `done` (1 bit). It is registered and pulses high for exactly one cycle coincident with each multiply update, i.e. the cycle after the DONE edge. It is 0 during and immediately after reset.
- Undefined: no `done` port; all other behaviour identical.

Test Plan:
- Hold reset=1 for 2 cycles with A=0, B=0 -> multiply=0 throughout and on the first cycle after release.
- Release reset, apply A=2, B=2, wait 12 cycles -> multiply=4 and stays 4 while operands are held.
- Change to A=5, B=3 -> multiply stays 4 until the next DONE, then 15 within 12 cycles; never shows an intermediate value.
- A=15, B=15 -> 225; A=0, B=9 -> 0; A=9, B=1 -> 9. Each checked after 12 cycles.
- Assert reset for 1 cycle mid-CALC with A=7, B=6 -> multiply=0 next edge. After release, 42 appears exactly WIDTH+2 edges after the first LOAD.
- With SEQ_MULT_DONE_EN: A=3, B=4 held -> done pulses every 6 cycles, each pulse 1 cycle wide, with multiply=12 on each pulse.

Source files
------------

// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - free-running unsigned shift-and-add multiplier (optional done pulse: SEQ_MULT_DONE_EN)
module sequential_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef SEQ_MULT_DONE_EN
    output logic                 done,
`endif
    output logic [2*WIDTH-1:0]   multiply
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   multiply_q, multiply_d;
`ifdef SEQ_MULT_DONE_EN
    logic                 done_q, done_d;
`endif

    // Next-state and datapath: capture operands, iterate WIDTH times with no early exit, publish.
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        acc_d      = acc_q;
        count_d    = count_q;
        multiply_d = multiply_q;
`ifdef SEQ_MULT_DONE_EN
        done_d     = 1'b0;
`endif
        case (state_q)
            LOAD: begin
                a_sh_d  = {{WIDTH{1'b0}}, A};
                b_sh_d  = B;
                acc_d   = '0;
                count_d = '0;
                state_d = CALC;
            end
            CALC: begin
                if (b_sh_q[0]) begin
                    acc_d = acc_q + a_sh_q;
                end
                a_sh_d  = a_sh_q << 1;
                b_sh_d  = b_sh_q >> 1;
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                multiply_d = acc_q;
`ifdef SEQ_MULT_DONE_EN
                done_d     = 1'b1;
`endif
                state_d    = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State register; synchronous reset discards any in-flight product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            multiply_q <= '0;
`ifdef SEQ_MULT_DONE_EN
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            multiply_q <= multiply_d;
`ifdef SEQ_MULT_DONE_EN
            done_q     <= done_d;
`endif
        end
    end

    assign multiply = multiply_q;
`ifdef SEQ_MULT_DONE_EN
    assign done     = done_q;
`endif

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - randomized self-checking bench for sequential_multiplier
module tb_sequential_multiplier;

    localparam int W = 4;
    localparam int P = W + 2;

    logic             clk;
    logic             reset;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2*W-1:0]   multiply;
`ifdef SEQ_MULT_DONE_EN
    logic             done;
`endif

    int n_checks;
    int n_fail;

    sequential_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
`ifdef SEQ_MULT_DONE_EN
        .done     (done),
`endif
        .multiply (multiply)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: operands sampled every P edges after reset release,
    // product published P-1 edges later, computed with plain arithmetic.
    int             m_edges;
    int             m_phase;
    int unsigned    m_latched;
    logic [2*W-1:0] exp_mult;
    logic           exp_done;

    always @(posedge clk) begin
        if (reset) begin
            m_edges  = 0;
            m_phase  = 0;
            exp_mult = '0;
            exp_done = 1'b0;
        end else begin
            m_edges  = m_edges + 1;
            m_phase  = (m_edges - 1) % P;
            exp_done = 1'b0;
            if (m_phase == 0) begin
                m_latched = int'(A) * int'(B);
            end
            if (m_phase == P - 1) begin
                exp_mult = m_latched[2*W-1:0];
                exp_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A = '0;
        B = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (multiply !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %0d expected 0", i, multiply);
            end
`ifdef SEQ_MULT_DONE_EN
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done cycle %0d: got %0b expected 0", i, done);
            end
`endif
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (multiply !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %0d expected 0", multiply);
        end
    endtask

    task automatic test_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] want, input string name);
        logic [2*W-1:0] prev;
        prev = multiply;
        A = a;
        B = b;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            n_checks++;
            if (multiply !== exp_mult) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %0d expected %0d", name, i, multiply, exp_mult);
            end
            n_checks++;
            if (multiply !== prev && multiply !== want) begin
                n_fail++;
                $display("FAIL %s_intermediate cycle %0d: got %0d expected %0d or %0d",
                         name, i, multiply, prev, want);
            end
        end
        n_checks++;
        if (multiply !== want) begin
            n_fail++;
            $display("FAIL %s_final: got %0d expected %0d", name, multiply, want);
        end
    endtask

    task automatic test_basic();
        test_pair(4'd2, 4'd2, 8'd4, "basic_2x2");
        for (int i = 0; i < P; i++) begin
            tick();
            n_checks++;
            if (multiply !== 8'd4) begin
                n_fail++;
                $display("FAIL basic_hold cycle %0d: got %0d expected 4", i, multiply);
            end
        end
        test_pair(4'd5, 4'd3, 8'd15, "change_5x3");
    endtask

    task automatic test_boundaries();
        test_pair(4'd15, 4'd15, 8'hE1, "max_15x15");
        test_pair(4'd0,  4'd9,  8'd0,  "zero_0x9");
        test_pair(4'd9,  4'd1,  8'd9,  "unit_9x1");
        test_pair(4'd6,  4'd0,  8'd0,  "zero_6x0");
    endtask

    task automatic test_reset_mid_calc();
        int  budget;
        bit  found;
        found  = 1'b0;
        budget = 0;
        while (!found && budget < 3 * P) begin
            tick();
            budget++;
            if (m_phase == 2) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midcalc_align: got timeout expected phase 2 within %0d cycles", 3 * P);
        end
        A = 4'd7;
        B = 4'd6;
        reset = 1'b1;
        tick();
        n_checks++;
        if (multiply !== 8'd0) begin
            n_fail++;
            $display("FAIL midcalc_reset: got %0d expected 0", multiply);
        end
        reset = 1'b0;
        for (int i = 1; i <= P; i++) begin
            tick();
            n_checks++;
            if (i < P && multiply !== 8'd0) begin
                n_fail++;
                $display("FAIL midcalc_early edge %0d: got %0d expected 0", i, multiply);
            end else if (i == P && multiply !== 8'd42) begin
                n_fail++;
                $display("FAIL midcalc_result edge %0d: got %0d expected 42", i, multiply);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int k = 0; k < 40; k++) begin
            A = W'($urandom);
            B = W'($urandom);
            hold = $urandom_range(1, 3 * P);
            for (int i = 0; i < hold; i++) begin
                tick();
                n_checks++;
                if (multiply !== exp_mult) begin
                    n_fail++;
                    $display("FAIL random pair %0d cycle %0d: got %0d expected %0d",
                             k, i, multiply, exp_mult);
                end
`ifdef SEQ_MULT_DONE_EN
                n_checks++;
                if (done !== exp_done) begin
                    n_fail++;
                    $display("FAIL random_done pair %0d cycle %0d: got %0b expected %0b",
                             k, i, done, exp_done);
                end
`endif
            end
        end
    endtask

`ifdef SEQ_MULT_DONE_EN
    task automatic test_done();
        int pulses;
        int last_pulse;
        A = 4'd3;
        B = 4'd4;
        for (int i = 0; i < 2 * P; i++) tick();
        pulses     = 0;
        last_pulse = -1;
        for (int i = 0; i < 3 * P; i++) begin
            tick();
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL done_pulse cycle %0d: got %0b expected %0b", i, done, exp_done);
            end
            if (done === 1'b1) begin
                pulses++;
                n_checks++;
                if (multiply !== 8'd12) begin
                    n_fail++;
                    $display("FAIL done_product cycle %0d: got %0d expected 12", i, multiply);
                end
                if (last_pulse >= 0) begin
                    n_checks++;
                    if (i - last_pulse != P) begin
                        n_fail++;
                        $display("FAIL done_spacing cycle %0d: got %0d expected %0d",
                                 i, i - last_pulse, P);
                    end
                end
                last_pulse = i;
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL done_count: got %0d expected 3", pulses);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        A        = '0;
        B        = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_reset_mid_calc();
        test_random();
`ifdef SEQ_MULT_DONE_EN
        test_done();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
